gssl_tx_framer_p: RTL and testbench
===================================

# gssl_tx_framer_p

Parametrised GSSL serial-link transmit framer, the next generation of the fixed 32-bit link transmitter. It builds 8b/10b-encoder character streams (data/K flag plus byte) from a header word and a DPRAM payload. Word width, address width, length width and inter-frame gap are configurable. TTC and ATC control-character requests are latched as sticky pending flags, so single-cycle pulses are never lost, and they are inserted at any character boundary without corrupting the frame. It sits between the link-layer DPRAM/trigger logic and the 8b/10b encoder.

## Interface
- DATA_BYTES, 4, bytes per word (1..8), sent LSB first
- ADDR_W, 8, DPRAM address width
- LEN_W, 8, payload-length width (words)
- IDLE_SYNC_MIN, 1, minimum SYNC characters between EOF and next SOF (0..15)
- GSSL_REFCLK  in  1  sole clock; all logic on rising edge
- rst_in  in  1  asynchronous, active-high reset
- CHS_CTRL  in  1  1: send checksum as-is; 0: send bitwise inverse
- tx_ttc_trigger  in  1  request one TTC K-char (sets pending)
- tx_atc_trigger  in  1  request ATC K-char plus status byte (sets pending)
- tx_atc_status_data  in  8  status byte sent after ATC
- tx_data_trigger  in  1  level; start frame when idle and gap satisfied
- tx_frame_head_data  in  8*DATA_BYTES  header word (word index 0)
- tx_frame_len  in  LEN_W  payload words L (0 = header only)
- tx_frame_base  in  ADDR_W  DPRAM address of payload word 1
- tx_dpram_q  in  8*DATA_BYTES  DPRAM read data, 1-cycle latency after tx_dpram_rd
- tx_dpram_raddress  out  ADDR_W  DPRAM read address
- tx_dpram_rd  out  1  one-cycle read strobe
- encode_k  out  1  1 = K-character
- encode_data  out  8  character byte
- tx_frame_busy  out  1  high from the SOF character through the EOF character
- tx_frame_done  out  1  one-cycle pulse coincident with the EOF character
- tx_state_debug  out  4  current state encoding

## Operation
- K codes: SOF 8'h00, EOF 8'h01, TTC 8'h02, ATC 8'h04, SYNC 8'h05.
- States: IDLE(0), SOF(1), BYTE(2), CHS(3), SYNC(4), EOF(5), CTL_TTC(6), CTL_ATC(7), CTL_STATUS(8).
- IDLE emits SYNC.
- Frame = SOF, then for each word index w=0..L: DATA_BYTES data bytes, one checksum byte, one SYNC; then EOF.
  - Word 0 is the header. Word w≥1 is DPRAM address tx_frame_base+w-1, mod 2^ADDR_W.
  - Total characters (no insertions) = 2 + (L+1)*(DATA_BYTES+2).
- Checksum for word w = (sum of its DATA_BYTES bytes + w[7:0]) mod 256. Emitted as-is if CHS_CTRL=1, else inverted. CHS_CTRL is sampled when the CHS character is generated.
- tx_frame_head_data, tx_frame_len and tx_frame_base are latched on the SOF decision. Later changes have no effect on the current frame.
- DPRAM read for word w+1 (when w<L):
  - tx_dpram_rd pulses with the address valid during byte 0 of word w.
  - q is captured during the CHS cycle of word w.
  - Exactly L strobes per frame.
- Pending flags:
  - ttc_pend and atc_pend are set by a trigger high at any edge; set wins over clear.
  - A trigger held high therefore repeats insertions.
- Insertion:
  - At every character decision, if ttc_pend: emit TTC and clear it. Else if atc_pend: emit ATC, then status, and clear it.
  - The framed sequence then resumes exactly where it stopped; insertions never split the ATC/status pair.
  - TTC has priority when both flags are pending.
  - Insertions in IDLE do not count toward IDLE_SYNC_MIN.
- tx_data_trigger while busy is ignored (not queued). A new SOF requires IDLE_SYNC_MIN SYNC characters emitted since EOF.
- tx_atc_status_data is sampled on the edge that drives the status byte.

## Timing
- All outputs are registered.
- Reset values: encode_k=1, encode_data=8'h05, tx_frame_busy=0, tx_frame_done=0, tx_dpram_rd=0, tx_dpram_raddress=0, tx_state_debug=0. Pending flags and counters clear.
- Trigger high at edge E in IDLE (gap met, nothing pending): the corresponding character is on encode_* after edge E+1.
- One character per clock; no stall input.
- Reset mid-frame: immediate abort to IDLE outputs; no EOF and no done pulse. Pending flags are lost.
- L = 2^LEN_W-1 must work; the word index counter is LEN_W+1 bits wide.

## Test plan
- DATA_BYTES=4, CHS_CTRL=0, L=0, header 32'h04030201, no DPRAM strobe: SOF, 01, 02, 03, 04, F5, SYNC, EOF. That is 8 characters with busy high all 8 and done high on EOF only.
- L=2, base=8'hFF, DPRAM[FF]=32'h0, DPRAM[00]=32'h11111111, CHS_CTRL=1: addresses FF then 00 (wrap); checksums 0A (header as above), 01, 46; 20 characters total.
- One-cycle tx_atc_trigger during byte 2 of word 1, status 8'hA5: ATC, A5 inserted, then byte 2 resumes; the checksum is unchanged.
- tx_ttc_trigger and tx_atc_trigger on the same edge: TTC, ATC, status in that order. A second TTC pulse during the ATC character is inserted after the status byte.
- IDLE_SYNC_MIN=3, tx_data_trigger held high: exactly 3 SYNC characters between EOF and the next SOF. A trigger pulse mid-frame starts no new frame.
- rst_in asserted during the CHS character: outputs return to reset values asynchronously. After release, a new frame starts cleanly at word index 0.

Source files
------------

// File: rtl/gssl_tx_framer_p.sv
// GSSL serial-link transmit framer: emits SOF / header + DPRAM payload words with
// per-word checksum and SYNC / EOF, with sticky TTC and ATC+status insertions.
module gssl_tx_framer_p #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_W        = 8,
    parameter int LEN_W         = 8,
    parameter int IDLE_SYNC_MIN = 1
) (
    input  logic                    GSSL_REFCLK,
    input  logic                    rst_in,
    input  logic                    CHS_CTRL,
    input  logic                    tx_ttc_trigger,
    input  logic                    tx_atc_trigger,
    input  logic [7:0]              tx_atc_status_data,
    input  logic                    tx_data_trigger,
    input  logic [8*DATA_BYTES-1:0] tx_frame_head_data,
    input  logic [LEN_W-1:0]        tx_frame_len,
    input  logic [ADDR_W-1:0]       tx_frame_base,
    input  logic [8*DATA_BYTES-1:0] tx_dpram_q,
    output logic [ADDR_W-1:0]       tx_dpram_raddress,
    output logic                    tx_dpram_rd,
    output logic                    encode_k,
    output logic [7:0]              encode_data,
    output logic                    tx_frame_busy,
    output logic                    tx_frame_done,
    output logic [3:0]              tx_state_debug
);
    localparam int WORD_W = 8 * DATA_BYTES;
    localparam int BW     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int WW     = LEN_W + 1;
    localparam logic [3:0]    GAP_MIN   = 4'(IDLE_SYNC_MIN);
    localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTES - 1);

    localparam logic [7:0] K_SOF  = 8'h00;
    localparam logic [7:0] K_EOF  = 8'h01;
    localparam logic [7:0] K_TTC  = 8'h02;
    localparam logic [7:0] K_ATC  = 8'h04;
    localparam logic [7:0] K_SYNC = 8'h05;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0, ST_SOF = 4'd1, ST_BYTE = 4'd2, ST_CHS = 4'd3, ST_SYNC = 4'd4,
        ST_EOF    = 4'd5, ST_TTC = 4'd6, ST_ATC  = 4'd7, ST_STATUS = 4'd8
    } state_t;

    // state_q is the character currently on the wire; nxt_q is where the frame resumes.
    state_t              state_q, state_d, nxt_q, nxt_d;
    logic [WW-1:0]       w_q, w_d;
    logic [BW-1:0]       b_q, b_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          gap_q, gap_d;
    logic                ttc_pend_q, ttc_pend_d, atc_pend_q, atc_pend_d, trig_q, trig_d;
    logic                k_q, k_d, busy_q, busy_d, done_q, done_d, rd_q, rd_d;
    logic [7:0]          data_q, data_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [7:0]          chs_sum, byte_sel;
    logic                more_words;

    always_comb begin
        chs_sum = 8'(w_q);
        for (int i = 0; i < DATA_BYTES; i++) begin
            chs_sum = chs_sum + word_q[8*i +: 8];
        end
    end

    assign byte_sel   = 8'(word_q >> {b_q, 3'b000});
    assign more_words = (w_q < {1'b0, len_q});

    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        w_d        = w_q;
        b_d        = b_q;
        word_d     = word_q;
        len_d      = len_q;
        base_d     = base_q;
        gap_d      = gap_q;
        ttc_pend_d = ttc_pend_q | tx_ttc_trigger;
        atc_pend_d = atc_pend_q | tx_atc_trigger;
        trig_d     = tx_data_trigger;
        k_d        = 1'b1;
        data_d     = K_SYNC;
        done_d     = 1'b0;
        rd_d       = 1'b0;
        raddr_d    = raddr_q;
        busy_d     = 1'b0;

        if (state_q == ST_ATC) begin
            state_d = ST_STATUS;
            k_d     = 1'b0;
            data_d  = tx_atc_status_data;
        end else if (ttc_pend_q) begin
            state_d    = ST_TTC;
            data_d     = K_TTC;
            ttc_pend_d = tx_ttc_trigger;
        end else if (atc_pend_q) begin
            state_d    = ST_ATC;
            data_d     = K_ATC;
            atc_pend_d = tx_atc_trigger;
        end else begin
            case (nxt_q)
                ST_BYTE: begin
                    state_d = ST_BYTE;
                    k_d     = 1'b0;
                    data_d  = byte_sel;
                    // Fetch the next word early so it is settled by the SYNC character.
                    if (b_q == '0 && more_words) begin
                        rd_d    = 1'b1;
                        raddr_d = base_q + ADDR_W'(w_q);
                    end
                    if (b_q == LAST_BYTE) begin
                        b_d   = '0;
                        nxt_d = ST_CHS;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                ST_CHS: begin
                    state_d = ST_CHS;
                    k_d     = 1'b0;
                    data_d  = CHS_CTRL ? chs_sum : ~chs_sum;
                    nxt_d   = ST_SYNC;
                end
                ST_SYNC: begin
                    state_d = ST_SYNC;
                    if (more_words) begin
                        word_d = tx_dpram_q;
                        w_d    = w_q + 1'b1;
                        nxt_d  = ST_BYTE;
                    end else begin
                        nxt_d = ST_EOF;
                    end
                end
                ST_EOF: begin
                    state_d = ST_EOF;
                    data_d  = K_EOF;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    nxt_d   = ST_IDLE;
                end
                default: begin
                    if (trig_q && gap_q >= GAP_MIN) begin
                        state_d = ST_SOF;
                        data_d  = K_SOF;
                        word_d  = tx_frame_head_data;
                        len_d   = tx_frame_len;
                        base_d  = tx_frame_base;
                        w_d     = '0;
                        b_d     = '0;
                        nxt_d   = ST_BYTE;
                    end else begin
                        state_d = ST_IDLE;
                        if (gap_q != 4'hF) gap_d = gap_q + 4'd1;
                    end
                end
            endcase
        end

        // Insertions outside a frame leave busy low; inside a frame they keep it high.
        busy_d = (state_d != ST_IDLE);
        if ((state_d == ST_TTC || state_d == ST_ATC || state_d == ST_STATUS) && nxt_q == ST_IDLE)
            busy_d = 1'b0;
    end

    always_ff @(posedge GSSL_REFCLK or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            nxt_q      <= ST_IDLE;
            w_q        <= '0;
            b_q        <= '0;
            word_q     <= '0;
            len_q      <= '0;
            base_q     <= '0;
            gap_q      <= '0;
            ttc_pend_q <= 1'b0;
            atc_pend_q <= 1'b0;
            trig_q     <= 1'b0;
            k_q        <= 1'b1;
            data_q     <= K_SYNC;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            raddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            w_q        <= w_d;
            b_q        <= b_d;
            word_q     <= word_d;
            len_q      <= len_d;
            base_q     <= base_d;
            gap_q      <= gap_d;
            ttc_pend_q <= ttc_pend_d;
            atc_pend_q <= atc_pend_d;
            trig_q     <= trig_d;
            k_q        <= k_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            raddr_q    <= raddr_d;
        end
    end

    assign encode_k          = k_q;
    assign encode_data       = data_q;
    assign tx_frame_busy     = busy_q;
    assign tx_frame_done     = done_q;
    assign tx_dpram_rd       = rd_q;
    assign tx_dpram_raddress = raddr_q;
    assign tx_state_debug    = state_q;
endmodule

// File: tb/tb_gssl_tx_framer_p.sv
// Bench for gssl_tx_framer_p: a character-queue reference model predicts every
// output character; a negedge monitor pops and compares against the DUT.
module tb_gssl_tx_framer_p;
    localparam int DB  = 4;
    localparam int AW  = 8;
    localparam int LW  = 8;
    localparam int MIN = 3;

    logic          clk;
    logic          rst_in;
    logic          chs_ctrl;
    logic          ttc_trig, atc_trig, data_trig;
    logic [7:0]    status;
    logic [8*DB-1:0] head;
    logic [LW-1:0] len;
    logic [AW-1:0] base;
    logic [8*DB-1:0] dpram_q;
    logic [AW-1:0] raddr;
    logic          rd, enc_k, busy, done;
    logic [7:0]    enc_data;
    logic [3:0]    st_dbg;

    logic [8*DB-1:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;

    gssl_tx_framer_p #(.DATA_BYTES(DB), .ADDR_W(AW), .LEN_W(LW), .IDLE_SYNC_MIN(MIN)) dut (
        .GSSL_REFCLK        (clk),
        .rst_in             (rst_in),
        .CHS_CTRL           (chs_ctrl),
        .tx_ttc_trigger     (ttc_trig),
        .tx_atc_trigger     (atc_trig),
        .tx_atc_status_data (status),
        .tx_data_trigger    (data_trig),
        .tx_frame_head_data (head),
        .tx_frame_len       (len),
        .tx_frame_base      (base),
        .tx_dpram_q         (dpram_q),
        .tx_dpram_raddress  (raddr),
        .tx_dpram_rd        (rd),
        .encode_k           (enc_k),
        .encode_data        (enc_data),
        .tx_frame_busy      (busy),
        .tx_frame_done      (done),
        .tx_state_debug     (st_dbg)
    );

    // ---------------- clock / DPRAM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd) dpram_q <= mem[raddr];
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] st;
        logic       k;
        logic [7:0] d;
        logic       rd;
        logic [7:0] addr;
        logic       is_chs;
    } fchar_t;

    fchar_t    fq[$];
    logic [23:0] exp_q[$];

    task automatic push_fc(input logic [3:0] st, input logic k, input logic [7:0] d,
                           input logic r, input logic [7:0] a, input logic c);
        fchar_t f;
        f.st = st; f.k = k; f.d = d; f.rd = r; f.addr = a; f.is_chs = c;
        fq.push_back(f);
    endtask

    // The whole frame as a list of characters, from the frame rules directly.
    task automatic build_frame(input int l, input int b0, input logic [8*DB-1:0] hd);
        logic [8*DB-1:0] word;
        int sum;
        push_fc(4'd1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int w = 0; w <= l; w++) begin
            word = (w == 0) ? hd : mem[(b0 + w - 1) % 256];
            sum = w % 256;
            for (int b = 0; b < DB; b++) begin
                sum += (word >> (8 * b)) & 'hFF;
                push_fc(4'd2, 1'b0, 8'((word >> (8 * b)) & 'hFF), (b == 0 && w < l),
                        8'((b0 + w) % 256), 1'b0);
            end
            push_fc(4'd3, 1'b0, 8'(sum % 256), 1'b0, 8'h00, 1'b1);
            push_fc(4'd4, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
        end
        push_fc(4'd5, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic m_ttc, m_atc, m_trig, m_prev_atc, m_busy, m_done, m_rd;
        logic [7:0] m_addr, m_d;
        logic [3:0] m_st;
        logic m_k;
        int m_gap;
        fchar_t c;
        m_ttc = 0; m_atc = 0; m_trig = 0; m_prev_atc = 0; m_addr = 0; m_gap = 0;
        forever begin
            @(posedge clk or posedge rst_in);
            if (rst_in) begin
                m_ttc = 0; m_atc = 0; m_trig = 0; m_prev_atc = 0; m_addr = 0; m_gap = 0;
                fq.delete();
                exp_q.delete();
            end else begin
                m_done = 0; m_rd = 0; m_k = 1;
                if (m_prev_atc) begin
                    m_st = 4'd8; m_k = 0; m_d = status; m_busy = (fq.size() != 0);
                end else if (m_ttc) begin
                    m_st = 4'd6; m_d = 8'h02; m_busy = (fq.size() != 0); m_ttc = 0;
                end else if (m_atc) begin
                    m_st = 4'd7; m_d = 8'h04; m_busy = (fq.size() != 0); m_atc = 0;
                end else begin
                    if (fq.size() == 0 && m_trig && m_gap >= MIN)
                        build_frame(int'(len), int'(base), head);
                    if (fq.size() != 0) begin
                        c = fq.pop_front();
                        m_st = c.st; m_k = c.k; m_d = c.d; m_rd = c.rd; m_busy = 1;
                        if (c.is_chs && !chs_ctrl) m_d = ~c.d;
                        if (c.rd) m_addr = c.addr;
                        if (c.st == 4'd5) begin
                            m_done = 1;
                            m_gap = 0;
                        end
                    end else begin
                        m_st = 4'd0; m_d = 8'h05; m_busy = 0;
                        m_gap++;
                    end
                end
                m_prev_atc = (m_st == 4'd7);
                m_ttc  = m_ttc | ttc_trig;
                m_atc  = m_atc | atc_trig;
                m_trig = data_trig;
                exp_q.push_back({m_st, m_k, m_d, m_busy, m_done, m_rd, m_addr});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [23:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                act_v = {st_dbg, enc_k, enc_data, busy, done, rd, raddr};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty: got %h, required a queued expectation", act_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        miscompares++;
                        $display("FAIL char @%0t: got st=%0d k=%b d=%h busy=%b done=%b rd=%b a=%h required st=%0d k=%b d=%h busy=%b done=%b rd=%b a=%h",
                                 $time, act_v[23:20], act_v[19], act_v[18:11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                                 exp_v[23:20], exp_v[19], exp_v[18:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_encode_k"},    32'(enc_k),    32'h1);
        check_val({tag, "_encode_data"}, 32'(enc_data), 32'h05);
        check_val({tag, "_busy"},        32'(busy),     32'h0);
        check_val({tag, "_done"},        32'(done),     32'h0);
        check_val({tag, "_rd"},          32'(rd),       32'h0);
        check_val({tag, "_raddr"},       32'(raddr),    32'h0);
        check_val({tag, "_state"},       32'(st_dbg),   32'h0);
    endtask

    task automatic start_frame(input int l, input int b, input logic [8*DB-1:0] hd, input logic chs);
        bit seen = 0;
        @(negedge clk); #1;
        len = LW'(l); base = AW'(b); head = hd; chs_ctrl = chs; data_trig = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL frame_start_timeout: got busy=0 required busy=1 within 60 cycles");
        end
        #1 data_trig = 0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL frame_done_timeout: got done=0 required done=1 within %0d cycles", budget);
        end
    endtask

    task automatic pulse(input bit t, input bit a, input logic [7:0] s);
        #1;
        ttc_trig = t; atc_trig = a; status = s;
        @(negedge clk); #1;
        ttc_trig = 0; atc_trig = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_in = 1; chs_ctrl = 0; ttc_trig = 0; atc_trig = 0; data_trig = 0;
        status = 8'h00; head = '0; len = '0; base = '0; dpram_q = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'hFF] = 32'h0;
        mem[8'h00] = 32'h11111111;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_in = 0;

        // Header-only frame, inverted checksum.
        start_frame(0, 0, 32'h04030201, 1'b0);
        wait_done(40);

        // Two payload words with address wrap, checksum as-is.
        start_frame(2, 8'hFF, 32'h04030201, 1'b1);
        wait_done(60);

        // ATC + status inside word 1 of a payload frame.
        start_frame(2, 8'hFF, 32'h04030201, 1'b1);
        repeat (8) @(negedge clk);
        pulse(0, 1, 8'hA5);
        wait_done(60);

        // Simultaneous TTC/ATC in idle, then a second TTC during the ATC character.
        repeat (6) @(negedge clk);
        pulse(1, 1, 8'h3C);
        @(negedge clk);
        pulse(1, 0, 8'h3C);
        repeat (6) @(negedge clk);

        // Longest frame.
        start_frame((1 << LW) - 1, $urandom_range(0, 255), $urandom, 1'b1);
        wait_done(2000);

        // Randomized traffic: held/pulsed frame trigger, sticky insertions.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            data_trig = ($urandom_range(0, 9) != 0);
            ttc_trig  = ($urandom_range(0, 24) == 0);
            atc_trig  = ($urandom_range(0, 24) == 0);
            status    = 8'($urandom);
            chs_ctrl  = 1'($urandom);
            len       = LW'($urandom_range(0, 5));
            base      = AW'($urandom);
            head      = $urandom;
        end
        data_trig = 0; ttc_trig = 0; atc_trig = 0;
        repeat (80) @(negedge clk);

        // Reset while the checksum character is on the wire.
        start_frame(1, $urandom_range(0, 255), $urandom, 1'b0);
        begin
            bit seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (st_dbg == 4'd3) seen = 1;
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL chs_wait_timeout: got no CHS state required CHS within 40 cycles");
            end
        end
        #1 rst_in = 1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk); #1 rst_in = 0;
        start_frame(1, $urandom_range(0, 255), $urandom, 1'b1);
        wait_done(60);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
